// File: rtl/sand_ram_arbiter_pkg.sv
// sand_pkg: shared types and sizing helper for the game-state RAM arbiter
package sand_pkg;
    typedef enum logic {GRANT_SIM, GRANT_BRUSH} grant_e;
    typedef enum logic {ST_SERVE, ST_CLEAR} arb_state_e;
    function automatic int depth(input int cols, input int rows);
        return cols * rows;
    endfunction
endpackage

// File: rtl/sand_ram_arbiter_if.sv
// sand_ram_arbiter_if: requester, clear-control and RAM-side signals of sand_ram_arbiter
interface sand_ram_arbiter_if #(
    parameter int ADDR_WIDTH = 19,
    parameter int DATA_WIDTH = 1
);
    logic                  sim_valid_i, sim_we_i, sim_ready_o, sim_rd_valid_o;
    logic [ADDR_WIDTH-1:0] sim_addr_i;
    logic [DATA_WIDTH-1:0] sim_wdata_i;
    logic                  brush_valid_i, brush_we_i, brush_ready_o, brush_rd_valid_o;
    logic [ADDR_WIDTH-1:0] brush_addr_i;
    logic [DATA_WIDTH-1:0] brush_wdata_i;
    logic [DATA_WIDTH-1:0] rd_data_o;
    logic                  clear_start_i, clear_busy_o, clear_done_o;
    logic [ADDR_WIDTH-1:0] ram_rd_address_o, ram_wr_address_o;
    logic [DATA_WIDTH-1:0] ram_wr_data_o, ram_rd_data_i;
    logic                  ram_wr_en_o;
    modport slave (
        input  sim_valid_i, sim_we_i, sim_addr_i, sim_wdata_i,
        input  brush_valid_i, brush_we_i, brush_addr_i, brush_wdata_i,
        input  clear_start_i, ram_rd_data_i,
        output sim_ready_o, sim_rd_valid_o, brush_ready_o, brush_rd_valid_o, rd_data_o,
        output clear_busy_o, clear_done_o,
        output ram_rd_address_o, ram_wr_address_o, ram_wr_data_o, ram_wr_en_o
    );
    modport master (
        output sim_valid_i, sim_we_i, sim_addr_i, sim_wdata_i,
        output brush_valid_i, brush_we_i, brush_addr_i, brush_wdata_i,
        output clear_start_i, ram_rd_data_i,
        input  sim_ready_o, sim_rd_valid_o, brush_ready_o, brush_rd_valid_o, rd_data_o,
        input  clear_busy_o, clear_done_o,
        input  ram_rd_address_o, ram_wr_address_o, ram_wr_data_o, ram_wr_en_o
    );
endinterface

// File: rtl/sand_ram_arbiter_rr.sv
// rr_arbiter_2: two-requester round-robin; last_grant moves only on a transfer
module rr_arbiter_2
    import sand_pkg::*;
(
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic [1:0] valid,
    input  logic       xfer,
    output logic [1:0] grant
);
    grant_e last_grant;
    // bit 0 = sim, bit 1 = brush; resetting to BRUSH lets sim win the first tie
    always_comb begin
        grant[0] = valid[0] & (~valid[1] | last_grant == GRANT_BRUSH);
        grant[1] = valid[1] & (~valid[0] | last_grant == GRANT_SIM);
    end
    always_ff @(posedge clk_i) begin
        if (reset_i) last_grant <= GRANT_BRUSH;
        else if (xfer) last_grant <= grant[1] ? GRANT_BRUSH : GRANT_SIM;
    end
endmodule

// File: rtl/sand_ram_arbiter.sv
// sand_ram_arbiter: shares the game-state RAM between sim engine and brush unit
// Optional full-frame clear sweep enabled by defining SAND_ARB_CLEAR_EN.
module sand_ram_arbiter
    import sand_pkg::*;
#(
    parameter int ACTIVE_COLUMNS = 640,
    parameter int ACTIVE_ROWS    = 480,
    parameter int ADDR_WIDTH     = $clog2(ACTIVE_COLUMNS * ACTIVE_ROWS),
    parameter int DATA_WIDTH     = 1,
    parameter int CLEAR_VALUE    = 0
) (
    input logic               clk_i,
    input logic               reset_i,
    sand_ram_arbiter_if.slave bus
);
    arb_state_e            state, next_state;
    logic [1:0]            grant;
    logic [ADDR_WIDTH-1:0] cnt, addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  serve, we, wr, rd, sim_rd_q, brush_rd_q;
    rr_arbiter_2 u_rr (
        .clk_i,
        .reset_i,
        .valid({bus.brush_valid_i, bus.sim_valid_i}),
        .xfer (serve & |grant),
        .grant
    );
    assign serve = state == ST_SERVE;
    assign we    = grant[1] ? bus.brush_we_i    : bus.sim_we_i;
    assign addr  = grant[1] ? bus.brush_addr_i  : bus.sim_addr_i;
    assign wdata = grant[1] ? bus.brush_wdata_i : bus.sim_wdata_i;
    assign wr    = serve & |grant & we;
    assign rd    = serve & |grant & ~we;
`ifdef SAND_ARB_CLEAR_EN
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(depth(ACTIVE_COLUMNS, ACTIVE_ROWS) - 1);
    logic done_q;
    // counter idles at 0 in SERVE so every sweep starts from address 0
    always_ff @(posedge clk_i) begin
        done_q <= ~reset_i & ~serve & cnt == LAST_ADDR;
        cnt    <= reset_i | serve ? '0 : cnt + 1'b1;
    end
    assign bus.clear_busy_o = ~serve;
    assign bus.clear_done_o = done_q;
`else
    assign cnt              = '0;
    assign bus.clear_busy_o = 1'b0;
    assign bus.clear_done_o = 1'b0;
`endif
    always_comb begin
        next_state           = ST_SERVE;
        bus.sim_ready_o      = serve & grant[0];
        bus.brush_ready_o    = serve & grant[1];
        bus.ram_wr_en_o      = serve ? wr : 1'b1;
        bus.ram_wr_address_o = serve ? (wr ? addr : '0) : cnt;
        bus.ram_wr_data_o    = serve ? (wr ? wdata : '0) : DATA_WIDTH'(CLEAR_VALUE);
        bus.ram_rd_address_o = rd ? addr : '0;
`ifdef SAND_ARB_CLEAR_EN
        next_state = serve ? (bus.clear_start_i ? ST_CLEAR : ST_SERVE)
                           : (cnt == LAST_ADDR ? ST_SERVE : ST_CLEAR);
`endif
    end
    always_ff @(posedge clk_i) begin
        state      <= reset_i ? ST_SERVE : next_state;
        sim_rd_q   <= ~reset_i & bus.sim_ready_o & bus.sim_valid_i & ~bus.sim_we_i;
        brush_rd_q <= ~reset_i & bus.brush_ready_o & bus.brush_valid_i & ~bus.brush_we_i;
    end
    assign bus.sim_rd_valid_o   = sim_rd_q;
    assign bus.brush_rd_valid_o = brush_rd_q;
    assign bus.rd_data_o        = bus.ram_rd_data_i;
endmodule

// File: tb/tb_sand_ram_arbiter.sv
// tb_sand_ram_arbiter: table-driven arbitration vectors plus clear-sweep sequences
module tb_sand_ram_arbiter;
    localparam int COLS = 4, ROWS = 2, DEPTH = 8, AW = 3, DW = 1;
    logic clk = 1'b0;
    logic reset_i = 1'b1;
    int   pass = 0, total = 0, dones;
    always #5 clk = ~clk;
    sand_ram_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
    sand_ram_arbiter #(
        .ACTIVE_COLUMNS(COLS), .ACTIVE_ROWS(ROWS), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CLEAR_VALUE(0)
    ) dut (.clk_i(clk), .reset_i(reset_i), .bus(bus));
    logic [DW-1:0] mem [DEPTH] = '{default: '0};
    always @(posedge clk) begin
        if (bus.ram_wr_en_o) mem[bus.ram_wr_address_o] <= bus.ram_wr_data_o;
        bus.ram_rd_data_i <= mem[bus.ram_rd_address_o];
    end
    typedef struct {
        int sv, swe, sa, swd, bv, bwe, ba, bwd;
        int sr, br, we, wa, wd, ra, srv, brv, rd;
    } vec_t;
    vec_t v [12];
    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask
    task automatic drive(input int sv, swe, sa, swd, bv, bwe, ba, bwd);
        bus.sim_valid_i   = 1'(sv);
        bus.sim_we_i      = 1'(swe);
        bus.sim_addr_i    = 3'(sa);
        bus.sim_wdata_i   = 1'(swd);
        bus.brush_valid_i = 1'(bv);
        bus.brush_we_i    = 1'(bwe);
        bus.brush_addr_i  = 3'(ba);
        bus.brush_wdata_i = 1'(bwd);
    endtask
    initial begin
        //        sv swe sa swd bv bwe ba bwd  sr br we wa wd ra  srv brv rd
        v[0]  = '{1, 1, 5, 1,  0, 0, 0, 0,   1, 0, 1, 5, 1, 0,  0, 0, 0};
        v[1]  = '{0, 0, 0, 0,  1, 1, 7, 1,   0, 1, 1, 7, 1, 0,  0, 0, 0};
        v[2]  = '{1, 0, 2, 0,  1, 1, 3, 1,   1, 0, 0, 0, 0, 2,  0, 0, 0};
        v[3]  = '{1, 0, 2, 0,  1, 1, 3, 1,   0, 1, 1, 3, 1, 0,  1, 0, 0};
        v[4]  = '{1, 0, 2, 0,  1, 1, 3, 1,   1, 0, 0, 0, 0, 2,  0, 0, 0};
        v[5]  = '{1, 0, 2, 0,  1, 1, 3, 1,   0, 1, 1, 3, 1, 0,  1, 0, 0};
        v[6]  = '{0, 0, 0, 0,  1, 0, 7, 0,   0, 1, 0, 0, 0, 7,  0, 0, 0};
        v[7]  = '{0, 0, 0, 0,  0, 0, 0, 0,   0, 0, 0, 0, 0, 0,  0, 1, 1};
        v[8]  = '{0, 0, 0, 0,  0, 0, 0, 0,   0, 0, 0, 0, 0, 0,  0, 0, 0};
        v[9]  = '{1, 1, 4, 1,  1, 0, 5, 0,   1, 0, 1, 4, 1, 0,  0, 0, 0};
        v[10] = '{1, 0, 5, 0,  1, 0, 5, 0,   0, 1, 0, 0, 0, 5,  0, 0, 0};
        v[11] = '{0, 0, 0, 0,  0, 0, 0, 0,   0, 0, 0, 0, 0, 0,  0, 1, 1};
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        bus.clear_start_i = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset sim_ready", bus.sim_ready_o, 0);
        chk("reset brush_ready", bus.brush_ready_o, 0);
        chk("reset sim_rd_valid", bus.sim_rd_valid_o, 0);
        chk("reset brush_rd_valid", bus.brush_rd_valid_o, 0);
        chk("reset wr_en", bus.ram_wr_en_o, 0);
        chk("reset busy", bus.clear_busy_o, 0);
        chk("reset done", bus.clear_done_o, 0);
        @(posedge clk);
        #1 reset_i = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1 drive(v[i].sv, v[i].swe, v[i].sa, v[i].swd, v[i].bv, v[i].bwe, v[i].ba, v[i].bwd);
            @(negedge clk);
            chk($sformatf("v%0d sim_ready", i), bus.sim_ready_o, v[i].sr);
            chk($sformatf("v%0d brush_ready", i), bus.brush_ready_o, v[i].br);
            chk($sformatf("v%0d wr_en", i), bus.ram_wr_en_o, v[i].we);
            chk($sformatf("v%0d wr_addr", i), bus.ram_wr_address_o, v[i].wa);
            chk($sformatf("v%0d wr_data", i), bus.ram_wr_data_o, v[i].wd);
            chk($sformatf("v%0d rd_addr", i), bus.ram_rd_address_o, v[i].ra);
            chk($sformatf("v%0d sim_rd_valid", i), bus.sim_rd_valid_o, v[i].srv);
            chk($sformatf("v%0d brush_rd_valid", i), bus.brush_rd_valid_o, v[i].brv);
            if (v[i].srv != 0 || v[i].brv != 0) chk($sformatf("v%0d rd_data", i), bus.rd_data_o, v[i].rd);
        end
`ifdef SAND_ARB_CLEAR_EN
        // sweep A: start alongside a sim read of addr 5, requesters keep pushing during the sweep
        @(posedge clk);
        #1 drive(1, 0, 5, 0, 0, 0, 0, 0);
        bus.clear_start_i = 1'b1;
        @(negedge clk);
        chk("A start sim_ready", bus.sim_ready_o, 1);
        chk("A start busy", bus.clear_busy_o, 0);
        for (int k = 0; k < DEPTH; k++) begin
            @(posedge clk);
            #1 bus.clear_start_i = 1'b0;
            if (k == 0) drive(1, 0, 1, 0, 1, 1, 6, 1);
            @(negedge clk);
            chk($sformatf("A%0d busy", k), bus.clear_busy_o, 1);
            chk($sformatf("A%0d readies", k), {bus.sim_ready_o, bus.brush_ready_o}, 0);
            chk($sformatf("A%0d wr_en", k), bus.ram_wr_en_o, 1);
            chk($sformatf("A%0d wr_addr", k), bus.ram_wr_address_o, k);
            chk($sformatf("A%0d wr_data", k), bus.ram_wr_data_o, 0);
            chk($sformatf("A%0d done", k), bus.clear_done_o, 0);
            if (k == 0) begin
                chk("A0 sim_rd_valid", bus.sim_rd_valid_o, 1);
                chk("A0 rd_data", bus.rd_data_o, 1);
            end
        end
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("A end busy", bus.clear_busy_o, 0);
        chk("A end done", bus.clear_done_o, 1);
        chk("A end brush_ready", bus.brush_ready_o, 1);
        chk("A end sim_ready", bus.sim_ready_o, 0);
        chk("A mem5 cleared", mem[5], 0);
        chk("A mem7 cleared", mem[7], 0);
        @(posedge clk);
        #1 drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("A post done", bus.clear_done_o, 0);
        // sweep B: a second start pulse mid-sweep must not restart it
        @(posedge clk);
        #1 bus.clear_start_i = 1'b1;
        @(negedge clk);
        dones = 0;
        for (int k = 0; k < DEPTH; k++) begin
            @(posedge clk);
            #1 bus.clear_start_i = 1'(k == 3);
            @(negedge clk);
            chk($sformatf("B%0d busy", k), bus.clear_busy_o, 1);
            chk($sformatf("B%0d wr_addr", k), bus.ram_wr_address_o, k);
            dones += int'(bus.clear_done_o);
        end
        for (int k = 0; k < 2; k++) begin
            @(posedge clk);
            #1 bus.clear_start_i = 1'b0;
            @(negedge clk);
            if (k == 0) chk("B end done", bus.clear_done_o, 1);
            chk($sformatf("B post%0d busy", k), bus.clear_busy_o, 0);
            dones += int'(bus.clear_done_o);
        end
        chk("B done count", dones, 1);
        // sweep C: reset lands in sweep cycle 4
        @(posedge clk);
        #1 bus.clear_start_i = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1 bus.clear_start_i = 1'b0;
            if (k == 4) reset_i = 1'b1;
            @(negedge clk);
            chk($sformatf("C%0d wr_addr", k), bus.ram_wr_address_o, k);
            chk($sformatf("C%0d busy", k), bus.clear_busy_o, 1);
        end
        @(posedge clk);
        #1 reset_i = 1'b0;
        @(negedge clk);
        chk("C abort busy", bus.clear_busy_o, 0);
        chk("C abort done", bus.clear_done_o, 0);
        chk("C abort wr_en", bus.ram_wr_en_o, 0);
        @(posedge clk);
        #1 drive(1, 1, 2, 1, 1, 1, 3, 1);
        @(negedge clk);
        chk("C after done", bus.clear_done_o, 0);
        chk("C after sim_ready", bus.sim_ready_o, 1);
        chk("C after brush_ready", bus.brush_ready_o, 0);
        chk("C after wr_addr", bus.ram_wr_address_o, 2);
`else
        @(posedge clk);
        #1 drive(1, 1, 2, 1, 0, 0, 0, 0);
        bus.clear_start_i = 1'b1;
        @(negedge clk);
        chk("noclr start sim_ready", bus.sim_ready_o, 1);
        @(posedge clk);
        #1 bus.clear_start_i = 1'b0;
        @(negedge clk);
        chk("noclr busy", bus.clear_busy_o, 0);
        chk("noclr sim_ready", bus.sim_ready_o, 1);
        chk("noclr wr_addr", bus.ram_wr_address_o, 2);
        @(posedge clk);
        @(negedge clk);
        chk("noclr done", bus.clear_done_o, 0);
`endif
        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule
